// File: rtl/fle_bank_config_ctrl_if.sv
// Configuration port bundle between the tile-level programming source and the
// fle bank-programming controller. With FLE_CFG_PARITY_EN defined the bundle
// also carries a per-chunk parity bit and a sticky error flag.
interface fle_bank_config_ctrl_if #(
  parameter int NUM_BITS = 66,
  parameter int CHUNK_W  = 6
);
  logic                start;
  logic [CHUNK_W-1:0]  cfg_data;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [0:NUM_BITS-1] bl;
  logic [0:NUM_BITS-1] wl;
  logic                busy;
  logic                done;
  logic                fabric_reset;
`ifdef FLE_CFG_PARITY_EN
  logic                cfg_parity;
  logic                err;

  modport master (
    output start, cfg_data, cfg_valid, cfg_parity,
    input  cfg_ready, bl, wl, busy, done, fabric_reset, err
  );
  modport slave (
    input  start, cfg_data, cfg_valid, cfg_parity,
    output cfg_ready, bl, wl, busy, done, fabric_reset, err
  );
`else
  modport master (
    output start, cfg_data, cfg_valid,
    input  cfg_ready, bl, wl, busy, done, fabric_reset
  );
  modport slave (
    input  start, cfg_data, cfg_valid,
    output cfg_ready, bl, wl, busy, done, fabric_reset
  );
`endif
endinterface

// File: rtl/fle_bank_config_ctrl.sv
// Memory-bank programming sequencer for one fle configuration SRAM.
// Streams CHUNK_W-bit chunks in, drives them on bl, strobes the matching wl
// group for WL_PULSE cycles, and keeps fabric_reset high until every cell is
// written. Optional per-chunk even-parity check: define FLE_CFG_PARITY_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing in progress, waiting for start
// LOAD  | cfg_ready high, waiting for the next chunk
// SETUP | chunk on bl, wl low (bl setup before the strobe)
// WRITE | wl high on the current chunk's cells for WL_PULSE cycles
// HOLD  | wl low, bl still held (bl hold after the strobe falls)
// DONE  | all cells written, fabric released, waiting for a new start
module fle_bank_config_ctrl #(
  parameter int NUM_BITS = 66,
  parameter int CHUNK_W  = 6,
  parameter int WL_PULSE = 2
) (
  input logic                  clk,
  input logic                  reset,
  fle_bank_config_ctrl_if.slave bus
);

  localparam int NUM_CHUNKS = (NUM_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PLS_W      = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [PLS_W-1:0] LAST_PULSE = PLS_W'(WL_PULSE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, WRITE, HOLD, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    chunk_cnt;
  logic [PLS_W-1:0]    pulse_cnt;
  logic [0:NUM_BITS-1] bl_q;
  logic [0:NUM_BITS-1] wl_q;
  logic                cfg_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                fabric_reset_q;
  logic [0:NUM_BITS-1] grp_sel;
  logic [0:NUM_BITS-1] bl_chunk;

  // Cells owned by the current chunk, and the incoming chunk mapped onto them.
  always_comb begin
    grp_sel  = '0;
    bl_chunk = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (i / CHUNK_W == int'(chunk_cnt)) begin
        grp_sel[i]  = 1'b1;
        bl_chunk[i] = bus.cfg_data[i % CHUNK_W];
      end
    end
  end

`ifdef FLE_CFG_PARITY_EN
  logic [CHUNK_W-1:0] in_range;
  logic               par_bad;
  logic               err_q;

  // Only bits that land on real cells take part in the parity of the last chunk.
  always_comb begin
    in_range = '0;
    for (int j = 0; j < CHUNK_W; j++) begin
      in_range[j] = (int'(chunk_cnt) * CHUNK_W + j) < NUM_BITS;
    end
  end

  assign par_bad = (^(bus.cfg_data & in_range)) != bus.cfg_parity;
  assign bus.err = err_q;
`endif

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      chunk_cnt      <= '0;
      pulse_cnt      <= '0;
      bl_q           <= '0;
      wl_q           <= '0;
      cfg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fabric_reset_q <= 1'b1;
`ifdef FLE_CFG_PARITY_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= LOAD;
            chunk_cnt      <= '0;
            cfg_ready_q    <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            fabric_reset_q <= 1'b1;
`ifdef FLE_CFG_PARITY_EN
            err_q          <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            cfg_ready_q <= 1'b0;
`ifdef FLE_CFG_PARITY_EN
            if (par_bad) begin
              // Abandon the whole program; the fabric stays in reset.
              state  <= IDLE;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              state <= SETUP;
              bl_q  <= bl_chunk;
            end
`else
            state <= SETUP;
            bl_q  <= bl_chunk;
`endif
          end
        end
        SETUP: begin
          state     <= WRITE;
          wl_q      <= grp_sel;
          pulse_cnt <= '0;
        end
        WRITE: begin
          if (pulse_cnt == LAST_PULSE) begin
            state <= HOLD;
            wl_q  <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        HOLD: begin
          bl_q <= '0;
          if (chunk_cnt == LAST_CHUNK) begin
            state          <= DONE;
            busy_q         <= 1'b0;
            done_q         <= 1'b1;
            fabric_reset_q <= 1'b0;
          end else begin
            state       <= LOAD;
            chunk_cnt   <= chunk_cnt + 1'b1;
            cfg_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bl           = bl_q;
  assign bus.wl           = wl_q;
  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fabric_reset = fabric_reset_q;

endmodule

// File: tb/tb_fle_bank_config_ctrl.sv
// Bench for fle_bank_config_ctrl: random bitstreams, random valid gaps and
// stray start pulses, checked against a cell-array model of the config SRAM
// (cells latch bl while their wl is high) and a cycle-count model.
module tb_fle_bank_config_ctrl;

  localparam int NB  = 66;
  localparam int CW  = 6;
  localparam int WP  = 2;
  localparam int NC  = (NB + CW - 1) / CW;
  localparam int CW2 = 8;
  localparam int NC2 = (NB + CW2 - 1) / CW2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bit exp_bits [NB];
  bit cells    [NB];
  int wl_cnt   [NB];

  always #5 clk = ~clk;

  fle_bank_config_ctrl_if #(.NUM_BITS(NB), .CHUNK_W(CW))  bus  ();
  fle_bank_config_ctrl_if #(.NUM_BITS(NB), .CHUNK_W(CW2)) bus8 ();

  fle_bank_config_ctrl #(.NUM_BITS(NB), .CHUNK_W(CW), .WL_PULSE(WP)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fle_bank_config_ctrl #(.NUM_BITS(NB), .CHUNK_W(CW2), .WL_PULSE(WP)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One programming pass on the CHUNK_W=6 instance.
  task automatic run_program(input bit ones, input bit force_c0, input int gmin, input int gmax,
                             input int abort_chunk, input int bad_chunk, input string nm);
    int cyc, chunk, gap, exp_cyc, g, done_cyc, idx;
    int chg_err, grp_err, bl_err, load_wl, cell_err, cnt_err;
    logic [0:NB-1] prev_bl, prev_wl;
    logic [CW-1:0] d;
    bit p;
    for (int i = 0; i < NB; i++) begin
      exp_bits[i] = ones ? 1'b1 : 1'($urandom % 2);
      wl_cnt[i]   = 0;
    end
    if (force_c0) for (int i = 0; i < CW; i++) exp_bits[i] = (i == 0 || i == 2);
    for (int i = 0; i < NB; i++) cells[i] = ~exp_bits[i];

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check({nm, "_start_busy"}, bus.busy, 1);
    check({nm, "_start_done"}, bus.done, 0);
    check({nm, "_start_frst"}, bus.fabric_reset, 1);
    check({nm, "_start_ready"}, bus.cfg_ready, 1);
`ifdef FLE_CFG_PARITY_EN
    check({nm, "_err_clr"}, bus.err, 0);
`endif

    cyc = 1; chunk = 0; exp_cyc = 1; done_cyc = -1;
    gap = $urandom_range(gmax, gmin);
    chg_err = 0; grp_err = 0; bl_err = 0; load_wl = 0;
    prev_bl = bus.bl; prev_wl = '0;
    while (cyc < 3000) begin
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (!bus.busy) break;
      if (bus.cfg_ready && bus.wl != '0) load_wl++;
      if (bus.wl != '0) begin
        g = -1;
        for (int i = 0; i < NB; i++) if (bus.wl[i] && g < 0) g = i / CW;
        if (g != chunk - 1) grp_err++;
        if (bus.bl != prev_bl) chg_err++;
        for (int i = 0; i < NB; i++) begin
          if (bus.wl[i] != (i / CW == g)) grp_err++;
          if (bus.bl[i] != ((i / CW == g) ? exp_bits[i] : 1'b0)) bl_err++;
          if (bus.wl[i]) begin
            wl_cnt[i]++;
            cells[i] = bus.bl[i];
          end
        end
        if (abort_chunk >= 0 && g == abort_chunk && prev_wl == '0) begin
          reset = 1'b1;
          bus.cfg_valid = 1'b0;
          bus.start = 1'b0;
          step();
          reset = 1'b0;
          check({nm, "_wl"}, longint'(bus.wl != '0), 0);
          check({nm, "_bl"}, longint'(bus.bl != '0), 0);
          check({nm, "_busy"}, bus.busy, 0);
          check({nm, "_frst"}, bus.fabric_reset, 1);
          check({nm, "_ready"}, bus.cfg_ready, 0);
          check({nm, "_done"}, bus.done, 0);
          return;
        end
      end
      bus.start = ($urandom_range(5, 0) == 0);
      if (bus.cfg_ready) begin
        if (gap > 0) begin
          bus.cfg_valid = 1'b0;
          bus.cfg_data  = CW'($urandom);
          gap--;
          exp_cyc++;
        end else begin
          d = '0; p = 1'b0;
          for (int j = 0; j < CW; j++) begin
            idx = chunk * CW + j;
            if (idx < NB) begin
              d[j] = exp_bits[idx];
              p    = p ^ exp_bits[idx];
            end else begin
              d[j] = 1'($urandom % 2);
            end
          end
          bus.cfg_valid = 1'b1;
          bus.cfg_data  = d;
`ifdef FLE_CFG_PARITY_EN
          bus.cfg_parity = (chunk == bad_chunk) ? ~p : p;
`endif
          exp_cyc += 3 + WP;
          chunk++;
          gap = $urandom_range(gmax, gmin);
        end
      end else begin
        bus.cfg_valid = 1'($urandom % 2);
        bus.cfg_data  = CW'($urandom);
`ifdef FLE_CFG_PARITY_EN
        bus.cfg_parity = 1'($urandom % 2);
`endif
      end
      prev_bl = bus.bl;
      prev_wl = bus.wl;
      step();
      cyc++;
    end
    bus.start = 1'b0;
    bus.cfg_valid = 1'b0;

`ifdef FLE_CFG_PARITY_EN
    if (bad_chunk >= 0) begin
      cnt_err = 0;
      for (int i = bad_chunk * CW; i < bad_chunk * CW + CW && i < NB; i++) cnt_err += wl_cnt[i];
      check({nm, "_err"}, bus.err, 1);
      check({nm, "_busy"}, bus.busy, 0);
      check({nm, "_frst"}, bus.fabric_reset, 1);
      check({nm, "_done"}, bus.done, 0);
      check({nm, "_bad_wl"}, cnt_err, 0);
      check({nm, "_no_done"}, done_cyc, -1);
      return;
    end
`endif

    cell_err = 0; cnt_err = 0;
    for (int i = 0; i < NB; i++) begin
      if (cells[i] != exp_bits[i]) cell_err++;
      if (wl_cnt[i] != WP) cnt_err++;
    end
    check({nm, "_done_cyc"}, done_cyc, exp_cyc);
    check({nm, "_frst_low"}, bus.fabric_reset, 0);
    check({nm, "_busy_low"}, bus.busy, 0);
    check({nm, "_bl_idle"}, longint'(bus.bl != '0), 0);
    check({nm, "_cells"}, cell_err, 0);
    check({nm, "_wl_cnt"}, cnt_err, 0);
    check({nm, "_wl_bl_chg"}, chg_err, 0);
    check({nm, "_wl_group"}, grp_err, 0);
    check({nm, "_bl_val"}, bl_err, 0);
    check({nm, "_wl_in_load"}, load_wl, 0);
  endtask

  // CHUNK_W=8 instance: 9 chunks, valid held high, last chunk 8'hFF.
  task automatic run_b();
    bit eb [NB];
    bit cb [NB];
    int cnt [NB];
    int cyc, k, cell_err, cnt_err;
    logic [CW2-1:0] d;
    for (int i = 0; i < NB; i++) begin
      eb[i]  = (i >= 64) ? 1'b1 : 1'($urandom % 2);
      cb[i]  = ~eb[i];
      cnt[i] = 0;
    end
    bus8.start = 1'b1;
    bus8.cfg_valid = 1'b1;
    step();
    bus8.start = 1'b0;
    cyc = 1; k = 0;
    while (cyc < 500 && !bus8.done) begin
      for (int i = 0; i < NB; i++) if (bus8.wl[i]) begin
        cnt[i]++;
        cb[i] = bus8.bl[i];
      end
      if (bus8.cfg_ready) begin
        d = '1;
        for (int j = 0; j < CW2; j++) if (k * CW2 + j < NB) d[j] = eb[k * CW2 + j];
        bus8.cfg_data = d;
`ifdef FLE_CFG_PARITY_EN
        bus8.cfg_parity = (k == NC2 - 1) ? (d[0] ^ d[1]) : ^d;
`endif
        k++;
      end else begin
        bus8.cfg_data = CW2'($urandom);
      end
      step();
      cyc++;
    end
    bus8.cfg_valid = 1'b0;
    cell_err = 0; cnt_err = 0;
    for (int i = 0; i < NB; i++) begin
      if (cb[i] != eb[i]) cell_err++;
      if (cnt[i] != WP) cnt_err++;
    end
    check("w8_done_cyc", cyc, 1 + NC2 * (3 + WP));
    check("w8_frst_low", bus8.fabric_reset, 0);
    check("w8_cells", cell_err, 0);
    check("w8_wl_cnt", cnt_err, 0);
    check("w8_last_wl", cnt[64] + cnt[65], 2 * WP);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    bus8.start = 1'b0; bus8.cfg_valid = 1'b0; bus8.cfg_data = '0;
`ifdef FLE_CFG_PARITY_EN
    bus.cfg_parity = 1'b0; bus8.cfg_parity = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) step();
    check("rst_bl", longint'(bus.bl != '0), 0);
    check("rst_wl", longint'(bus.wl != '0), 0);
    check("rst_ready", bus.cfg_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_frst", bus.fabric_reset, 1);
    reset = 1'b0;
    step();

    run_program(1'b1, 1'b0, 0, 0, -1, -1, "ones");
    run_program(1'b0, 1'b1, 3, 3, -1, -1, "gap3");
    run_program(1'b0, 1'b0, 0, 4, -1, -1, "rnd");
    run_program(1'b0, 1'b0, 0, 2, 4, -1, "abort");
    repeat (2) step();
    run_program(1'b0, 1'b0, 0, 1, -1, -1, "reprog");
`ifdef FLE_CFG_PARITY_EN
    run_program(1'b0, 1'b0, 0, 1, -1, 2, "par");
    run_program(1'b0, 1'b0, 0, 1, -1, -1, "par_rec");
`endif
    run_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
